// File: rtl/if_aligner.sv
// Instruction realignment buffer between the fetch unit and IF/ID.
// Splits word-aligned fetch words into RV32IC instructions and fault slots.
module if_aligner #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_fault_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_data_o,
    output logic        inst_is_rvc_o,
    output logic        inst_page_fault_o,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i
);

    logic [15:0] hb_q [4];
    logic [15:0] hb_d [4];
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic        skip_lo_q, skip_lo_d;
    logic        fault_pend_q, fault_pend_d;
    logic        fault_sent_q, fault_sent_d;

    logic        is32;
    logic        avail16;
    logic        avail32;
    logic        inst_ok;
    logic        fault_slot;
    logic        accept;
    logic        consume;
    logic [2:0]  cons_n;
    logic [2:0]  app_n;
    logic [1:0]  wr0;
    logic [1:0]  wr1;

    assign is32       = (hb_q[0][1:0] == 2'b11);
    assign avail16    = (cnt_q != 3'd0) && !is32;
    assign avail32    = (cnt_q >= 3'd2) && is32;
    assign inst_ok    = avail16 || avail32;
    assign fault_slot = !inst_ok && fault_pend_q && !fault_sent_q;

    // Ready looks only at registered state (plus the flush override), so
    // the fetch side never sees a combinational path from inst_ready_i.
    assign fetch_ready_o = !flush_i && !fault_pend_q && (cnt_q <= 3'd2);
    assign inst_valid_o  = !flush_i && (inst_ok || fault_slot);

    assign accept  = fetch_valid_i && fetch_ready_o;
    assign consume = inst_valid_o && inst_ready_i;

    assign inst_pc_o         = head_pc_q;
    assign inst_is_rvc_o     = avail16;
    assign inst_page_fault_o = fault_slot;

    always_comb begin
        inst_data_o = 32'h0;
        if (avail32) begin
            inst_data_o = {hb_q[1], hb_q[0]};
        end else if (avail16) begin
            inst_data_o = {16'h0, hb_q[0]};
        end
    end

    always_comb begin
        cons_n = 3'd0;
        if (consume && avail32) begin
            cons_n = 3'd2;
        end else if (consume && avail16) begin
            cons_n = 3'd1;
        end
    end

    // Incoming halfwords land right after whatever survives this cycle's shift.
    assign wr0 = cnt_q[1:0] - cons_n[1:0];
    assign wr1 = wr0 + 2'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hb_d[i] = hb_q[i];
        end
        app_n        = 3'd0;
        skip_lo_d    = skip_lo_q;
        fault_pend_d = fault_pend_q;
        fault_sent_d = fault_sent_q;
        head_pc_d    = head_pc_q + {28'h0, cons_n, 1'b0};

        if (cons_n == 3'd1) begin
            hb_d[0] = hb_q[1];
            hb_d[1] = hb_q[2];
            hb_d[2] = hb_q[3];
        end else if (cons_n == 3'd2) begin
            hb_d[0] = hb_q[2];
            hb_d[1] = hb_q[3];
        end

        if (accept && fetch_fault_i) begin
            fault_pend_d = 1'b1;
            skip_lo_d    = 1'b0;
        end else if (accept && skip_lo_q) begin
            hb_d[wr0] = fetch_data_i[31:16];
            app_n     = 3'd1;
            skip_lo_d = 1'b0;
        end else if (accept) begin
            hb_d[wr0] = fetch_data_i[15:0];
            hb_d[wr1] = fetch_data_i[31:16];
            app_n     = 3'd2;
        end

        if (consume && fault_slot) begin
            fault_sent_d = 1'b1;
        end

        cnt_d = cnt_q + app_n - cons_n;

        if (flush_i) begin
            cnt_d        = 3'd0;
            fault_pend_d = 1'b0;
            fault_sent_d = 1'b0;
            head_pc_d    = redirect_pc_i & 32'hFFFF_FFFE;
            skip_lo_d    = redirect_pc_i[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hb_q[i] <= 16'h0;
            end
            cnt_q        <= 3'd0;
            head_pc_q    <= RESET_PC;
            skip_lo_q    <= 1'b0;
            fault_pend_q <= 1'b0;
            fault_sent_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hb_q[i] <= hb_d[i];
            end
            cnt_q        <= cnt_d;
            head_pc_q    <= head_pc_d;
            skip_lo_q    <= skip_lo_d;
            fault_pend_q <= fault_pend_d;
            fault_sent_q <= fault_sent_d;
        end
    end

endmodule

// File: tb/tb_if_aligner.sv
// Directed bench for if_aligner: alignment, straddling, redirect,
// page-fault slots, stalls and reset.
module tb_if_aligner;

    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i;
    logic        fetch_fault_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_data_o;
    logic        inst_is_rvc_o;
    logic        inst_page_fault_o;
    logic        flush_i;
    logic [31:0] redirect_pc_i;

    logic [66:0] obs;
    int          n_cmp;
    int          n_mis;

    assign obs = {inst_valid_o, inst_pc_o, inst_data_o,
                  inst_is_rvc_o, inst_page_fault_o};

    if_aligner #(.RESET_PC(32'h3000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_ready_o    (fetch_ready_o),
        .fetch_data_i     (fetch_data_i),
        .fetch_fault_i    (fetch_fault_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_pc_o        (inst_pc_o),
        .inst_data_o      (inst_data_o),
        .inst_is_rvc_o    (inst_is_rvc_o),
        .inst_page_fault_o(inst_page_fault_o),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        fetch_valid_i = 1'b0;
        fetch_data_i  = 32'h0;
        fetch_fault_i = 1'b0;
        inst_ready_i  = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_ready_o, obs} !== {1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL reset_values: got %h want %h", {fetch_ready_o, obs},
                     {1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_aligned32();
        logic        ev;
        logic [31:0] epc;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            fetch_valid_i = (i < 4);
            fetch_data_i  = 32'h0000_0013;
            inst_ready_i  = 1'b1;
            #1;
            ev  = (i >= 1) && (i <= 4);
            epc = 32'h3000_0000 + 32'(4 * (i - 1));
            n_cmp++;
            if (inst_valid_o !== ev) begin
                n_mis++;
                $display("FAIL aligned32_valid[%0d]: got %b want %b", i, inst_valid_o, ev);
            end
            if (ev) begin
                n_cmp++;
                if (obs !== {1'b1, epc, 32'h0000_0013, 1'b0, 1'b0}) begin
                    n_mis++;
                    $display("FAIL aligned32_slot[%0d]: got %h want %h", i, obs,
                             {1'b1, epc, 32'h0000_0013, 1'b0, 1'b0});
                end
            end
            n_cmp++;
            if (fetch_ready_o !== 1'b1) begin
                n_mis++;
                $display("FAIL aligned32_ready[%0d]: got %b want 1", i, fetch_ready_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rvc_pair();
        apply_reset();
        inst_ready_i  = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h4501_0505;
        #1;
        n_cmp++;
        if (inst_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL rvc_latency: got valid %b want 0", inst_valid_o);
        end
        @(negedge clk);
        fetch_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0000, 32'h0000_0505, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL rvc_first: got %h want %h", obs,
                     {1'b1, 32'h3000_0000, 32'h0000_0505, 1'b1, 1'b0});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0002, 32'h0000_4501, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL rvc_second: got %h want %h", obs,
                     {1'b1, 32'h3000_0002, 32'h0000_4501, 1'b1, 1'b0});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (inst_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL rvc_drained: got valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_straddle();
        apply_reset();
        inst_ready_i  = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0513_4501;
        @(negedge clk);
        fetch_data_i = 32'h0001_00A5;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0000, 32'h0000_4501, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL straddle_rvc0: got %h want %h", obs,
                     {1'b1, 32'h3000_0000, 32'h0000_4501, 1'b1, 1'b0});
        end
        @(negedge clk);
        fetch_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0002, 32'h00A5_0513, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL straddle_32: got %h want %h", obs,
                     {1'b1, 32'h3000_0002, 32'h00A5_0513, 1'b0, 1'b0});
        end
        n_cmp++;
        if (fetch_ready_o !== 1'b0) begin
            n_mis++;
            $display("FAIL straddle_ready_cnt3: got %b want 0", fetch_ready_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0006, 32'h0000_0001, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL straddle_rvc1: got %h want %h", obs,
                     {1'b1, 32'h3000_0006, 32'h0000_0001, 1'b1, 1'b0});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (inst_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL straddle_drained: got valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_flush_redirect();
        apply_reset();
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0000_0013;
        @(negedge clk);
        flush_i       = 1'b1;
        redirect_pc_i = 32'h3000_0103;
        fetch_data_i  = 32'h1111_1111;
        #1;
        n_cmp++;
        if ({fetch_ready_o, inst_valid_o} !== 2'b00) begin
            n_mis++;
            $display("FAIL flush_forces_low: got %b want 00", {fetch_ready_o, inst_valid_o});
        end
        @(negedge clk);
        flush_i      = 1'b0;
        fetch_data_i = 32'h4501_0505;
        inst_ready_i = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_ready_o, inst_valid_o} !== 2'b10) begin
            n_mis++;
            $display("FAIL flush_empty: got %b want 10", {fetch_ready_o, inst_valid_o});
        end
        @(negedge clk);
        fetch_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0102, 32'h0000_4501, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL redirect_slot: got %h want %h", obs,
                     {1'b1, 32'h3000_0102, 32'h0000_4501, 1'b1, 1'b0});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (inst_valid_o !== 1'b0) begin
            n_mis++;
            $display("FAIL redirect_single: got valid %b want 0", inst_valid_o);
        end
    endtask

    task automatic test_fault();
        apply_reset();
        inst_ready_i  = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0513_4501;
        @(negedge clk);
        fetch_data_i  = 32'hDEAD_BEEF;
        fetch_fault_i = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_ready_o, obs} !== {1'b1, 1'b1, 32'h3000_0000, 32'h0000_4501, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL fault_pre_rvc: got %h want %h", {fetch_ready_o, obs},
                     {1'b1, 1'b1, 32'h3000_0000, 32'h0000_4501, 1'b1, 1'b0});
        end
        @(negedge clk);
        fetch_valid_i = 1'b0;
        fetch_fault_i = 1'b0;
        #1;
        n_cmp++;
        if ({fetch_ready_o, obs} !== {1'b0, 1'b1, 32'h3000_0002, 32'h0, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL fault_slot: got %h want %h", {fetch_ready_o, obs},
                     {1'b0, 1'b1, 32'h3000_0002, 32'h0, 1'b0, 1'b1});
        end
        @(negedge clk);
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0000_0013;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({fetch_ready_o, inst_valid_o} !== 2'b00) begin
                n_mis++;
                $display("FAIL fault_blocked[%0d]: got %b want 00", i,
                         {fetch_ready_o, inst_valid_o});
            end
            @(negedge clk);
        end
        fetch_valid_i = 1'b0;
        flush_i       = 1'b1;
        redirect_pc_i = 32'h3000_0200;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_cmp++;
        if ({fetch_ready_o, inst_valid_o} !== 2'b10) begin
            n_mis++;
            $display("FAIL fault_cleared: got %b want 10", {fetch_ready_o, inst_valid_o});
        end
        fetch_valid_i = 1'b1;
        @(negedge clk);
        fetch_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (obs !== {1'b1, 32'h3000_0200, 32'h0000_0013, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL fault_recover: got %h want %h", obs,
                     {1'b1, 32'h3000_0200, 32'h0000_0013, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int acc;
        acc = 0;
        apply_reset();
        inst_ready_i  = 1'b0;
        fetch_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_data_i = 32'h0000_0093 + (32'(i) << 20);
            #1;
            if (fetch_ready_o) acc++;
            if (i == 0) begin
                n_cmp++;
                if (inst_valid_o !== 1'b0) begin
                    n_mis++;
                    $display("FAIL stall_first: got valid %b want 0", inst_valid_o);
                end
            end else begin
                n_cmp++;
                if (obs !== {1'b1, 32'h3000_0000, 32'h0000_0093, 1'b0, 1'b0}) begin
                    n_mis++;
                    $display("FAIL stall_hold[%0d]: got %h want %h", i, obs,
                             {1'b1, 32'h3000_0000, 32'h0000_0093, 1'b0, 1'b0});
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (acc !== 2) begin
            n_mis++;
            $display("FAIL stall_accepts: got %0d want 2", acc);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({fetch_ready_o, obs} !== {1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL async_reset: got %h want %h", {fetch_ready_o, obs},
                     {1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_stall_flush();
        apply_reset();
        inst_ready_i  = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_data_i  = 32'h0000_0013;
        repeat (3) @(negedge clk);
        flush_i       = 1'b1;
        redirect_pc_i = 32'h3000_0040;
        #1;
        n_cmp++;
        if ({fetch_ready_o, inst_valid_o} !== 2'b00) begin
            n_mis++;
            $display("FAIL stall_flush_cycle: got %b want 00", {fetch_ready_o, inst_valid_o});
        end
        @(negedge clk);
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({fetch_ready_o, inst_valid_o, inst_pc_o} !== {2'b10, 32'h3000_0040}) begin
            n_mis++;
            $display("FAIL stall_flush_after: got %h want %h",
                     {fetch_ready_o, inst_valid_o, inst_pc_o}, {2'b10, 32'h3000_0040});
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst   = 1'b0;
        test_reset();
        test_aligned32();
        test_rvc_pair();
        test_straddle();
        test_flush_redirect();
        test_fault();
        test_stall();
        test_stall_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
